nios_mult_pipe: RTL and testbench
=================================

Name: nios_mult_pipe

Overview:
- Parametrised, pipelined integer multiplier for the Nios II-class CPU execute/memory stages.
- Next generation of the existing three-partial-product multiply cell. It computes all four half-width partial products and accumulates them internally, so the CPU receives a finished result.
- Supports signed, unsigned and mixed-sign operands, low-word and high-word results, valid tracking, stall and flush.
- Sits between the E-stage operand muxes and the M/W-stage result mux.

Parameters:
- DATA_W, 32: operand width. Legal values are 16, 32 and 64. The half width is H = DATA_W/2.
- PIPE_STAGES, 2: latency in cycles. Legal values are 2 and 3. A value of 3 adds a registered output stage.
- PERF_CNT_W, 32: width of the optional completed-operation counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- E_src1  in  DATA_W  operand A.
- E_src2  in  DATA_W  operand B.
- E_op  in  2  operation select:
  - 0 = MUL: low word.
  - 1 = MULH: high word, signed × signed.
  - 2 = MULHSU: high word, signed A × unsigned B.
  - 3 = MULHU: high word, unsigned × unsigned.
- E_valid  in  1  operands are valid this cycle; sampled only when M_en=1.
- M_en  in  1  pipeline advance enable. When 0, every stage register and valid bit holds.
- flush  in  1  synchronous kill of all in-flight operations.
- M_mul_result  out  DATA_W  selected result word.
- M_mul_valid  out  1  M_mul_result is valid this cycle.
- M_mul_busy  out  1  OR of all in-flight valid bits, excluding the final stage.
- perf_mul_count  out  PERF_CNT_W  completed-operation count. Present only with MULT_PIPE_PERF_CNT_EN.

Behaviour:
- Reset (reset_n=0, asynchronous): all stage registers, valid bits, M_mul_result, M_mul_valid and M_mul_busy go to 0. Reset mid-operation discards every in-flight operation; no stale valid is produced after release.
- Stage 1, the product stage. It registers the following:
  - pLL = A[H-1:0]×B[H-1:0]
  - pLH = A[H-1:0]×B[DATA_W-1:H]
  - pHL = A[DATA_W-1:H]×B[H-1:0]
  - pHH = A[DATA_W-1:H]×B[DATA_W-1:H]
  - all four products are unsigned and 2H bits wide.
  - also registered: E_op, a sign-correction term, and valid (v1 = E_valid).
- Sign-correction term, computed from the raw operands:
  - corr = (signA ? B_eff : 0) + (signB ? A : 0), truncated to DATA_W bits.
  - signA = A[DATA_W-1] & (op==1 | op==2).
  - signB = B[DATA_W-1] & (op==1).
  - B_eff = B.
- Stage 2, the accumulate stage:
  - P = pLL + (pLH<<H) + (pHL<<H) + (pHH<<DATA_W), computed in 2·DATA_W bits with no overflow.
  - hi = P[2DATA_W-1:DATA_W] − corr, modulo 2^DATA_W.
  - Result = P[DATA_W-1:0] for op 0; hi for ops 1–3.
  - The low word needs no correction for any op.
- Output timing:
  - PIPE_STAGES=2: the stage-2 register drives M_mul_result and M_mul_valid directly.
  - PIPE_STAGES=3: one further register stage is added.
- Latency: an operation accepted at edge N (E_valid=1, M_en=1) appears with M_mul_valid=1 after edge N+PIPE_STAGES-1, provided M_en stays 1. Every M_en=0 cycle adds one cycle of latency.
- Throughput: one operation per M_en=1 cycle; back-to-back issue is allowed.
- M_en=0: all registers hold, including M_mul_valid and M_mul_result. A valid result stays presented until the next M_en=1 edge.
- flush=1 on an edge:
  - all valid bits clear, regardless of M_en.
  - flush takes priority over simultaneous E_valid, which is dropped.
  - datapath registers may keep stale data, but must never be presented with valid=1.
- M_mul_result when M_mul_valid=0: don't-care. The bench must not check it.
- E_op values are all legal; there is no error state.

Optional Feature:
- Macro: MULT_PIPE_PERF_CNT_EN.
- Defined:
  - perf_mul_count exists. It resets to 0.
  - It increments by 1 on every edge where the final-stage valid is 1 and M_en=1, i.e. the result is consumed.
  - It wraps from 2^PERF_CNT_W−1 to 0.
  - A flush in the same cycle still counts the consumed result.
- Undefined: the port and counter are absent; no other behaviour changes.

Test Plan:
- DATA_W=32, PIPE_STAGES=2, op=0, A=0x0001_0003, B=0x0002_0005, M_en=1 → M_mul_valid one edge later after accept, result 0x000B_000F.
- op=1, A=0xFFFF_FFFF, B=0xFFFF_FFFF → result 0x0000_0000. With op=3 and the same operands → result 0xFFFF_FFFE. With op=2 → result 0xFFFF_FFFF.
- Back-to-back issue of 4 ops (A=1..4, B=0x8000_0000, op=3) → four consecutive valid cycles with results 0, 1, 1, 2.
- Accept op, then M_en=0 for 3 cycles mid-flight → valid and result frozen; result emerges exactly 3 cycles later than nominal, and exactly once.
- Accept op, assert flush with E_valid=1 on the next edge; also assert reset_n=0 mid-flight in a separate run → no M_mul_valid produced, M_mul_busy=0, all outputs 0 after reset.
- With MULT_PIPE_PERF_CNT_EN, PERF_CNT_W=4: 17 consumed ops → perf_mul_count=1 (wrap). 2 ops stalled and then flushed → count unchanged.

Source files
------------

// File: rtl/nios_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier with four half-width partial products, stall and flush.
// Optional completed-operation counter enabled by defining MULT_PIPE_PERF_CNT_EN.
module nios_mult_pipe #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned PERF_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     E_src1,
  input  logic [DATA_W-1:0]     E_src2,
  input  logic [1:0]            E_op,
  input  logic                  E_valid,
  input  logic                  M_en,
  input  logic                  flush,
  output logic [DATA_W-1:0]     M_mul_result,
  output logic                  M_mul_valid,
  output logic                  M_mul_busy
`ifdef MULT_PIPE_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_mul_count
`endif
);

  localparam int unsigned H = DATA_W / 2;

  logic [H-1:0]      a_lo, a_hi, b_lo, b_hi;
  logic              sign_a, sign_b;
  logic [DATA_W-1:0] corr;

  assign a_lo = E_src1[H-1:0];
  assign a_hi = E_src1[DATA_W-1:H];
  assign b_lo = E_src2[H-1:0];
  assign b_hi = E_src2[DATA_W-1:H];

  // Unsigned partial products are fixed up in the high word by subtracting this term.
  always_comb begin
    sign_a = E_src1[DATA_W-1] & ((E_op == 2'd1) | (E_op == 2'd2));
    sign_b = E_src2[DATA_W-1] & (E_op == 2'd1);
    corr   = (sign_a ? E_src2 : '0) + (sign_b ? E_src1 : '0);
  end

  // Stage 1: partial products
  logic [DATA_W-1:0] pll_q, pll_d, plh_q, plh_d, phl_q, phl_d, phh_q, phh_d;
  logic [DATA_W-1:0] corr1_q, corr1_d;
  logic [1:0]        op1_q, op1_d;
  logic              v1_q, v1_d;

  always_comb begin
    pll_d   = pll_q;
    plh_d   = plh_q;
    phl_d   = phl_q;
    phh_d   = phh_q;
    corr1_d = corr1_q;
    op1_d   = op1_q;
    if (M_en) begin
      pll_d   = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
      plh_d   = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_hi};
      phl_d   = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_lo};
      phh_d   = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_hi};
      corr1_d = corr;
      op1_d   = E_op;
    end
    if (flush)     v1_d = 1'b0;
    else if (M_en) v1_d = E_valid;
    else           v1_d = v1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_q   <= '0;
      plh_q   <= '0;
      phl_q   <= '0;
      phh_q   <= '0;
      corr1_q <= '0;
      op1_q   <= '0;
      v1_q    <= 1'b0;
    end else begin
      pll_q   <= pll_d;
      plh_q   <= plh_d;
      phl_q   <= phl_d;
      phh_q   <= phh_d;
      corr1_q <= corr1_d;
      op1_q   <= op1_d;
      v1_q    <= v1_d;
    end
  end

  // Stage 2: accumulate and select word
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   hi_word, res2;
  logic [DATA_W-1:0]   res2_q, res2_d;
  logic                v2_q, v2_d;

  always_comb begin
    prod = {{DATA_W{1'b0}}, pll_q}
         + {{H{1'b0}}, plh_q, {H{1'b0}}}
         + {{H{1'b0}}, phl_q, {H{1'b0}}}
         + {phh_q, {DATA_W{1'b0}}};
    hi_word = prod[2*DATA_W-1:DATA_W] - corr1_q;
    res2    = (op1_q == 2'd0) ? prod[DATA_W-1:0] : hi_word;
    res2_d  = M_en ? res2 : res2_q;
    if (flush)     v2_d = 1'b0;
    else if (M_en) v2_d = v1_q;
    else           v2_d = v2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res2_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      res2_q <= res2_d;
      v2_q   <= v2_d;
    end
  end

  if (PIPE_STAGES == 3) begin : g_out_stage
    logic [DATA_W-1:0] res3_q, res3_d;
    logic              v3_q, v3_d;

    always_comb begin
      res3_d = M_en ? res2_q : res3_q;
      if (flush)     v3_d = 1'b0;
      else if (M_en) v3_d = v2_q;
      else           v3_d = v3_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        res3_q <= '0;
        v3_q   <= 1'b0;
      end else begin
        res3_q <= res3_d;
        v3_q   <= v3_d;
      end
    end

    assign M_mul_result = res3_q;
    assign M_mul_valid  = v3_q;
    assign M_mul_busy   = v1_q | v2_q;
  end else begin : g_no_out_stage
    assign M_mul_result = res2_q;
    assign M_mul_valid  = v2_q;
    assign M_mul_busy   = v1_q;
  end

`ifdef MULT_PIPE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_q, perf_d;

  // A result is consumed whenever it is presented on an advancing edge, even if flushed.
  always_comb begin
    perf_d = perf_q;
    if (M_mul_valid && M_en) perf_d = perf_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_mul_count = perf_q;
`endif

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Randomised and directed bench for nios_mult_pipe against a queue-based pipeline model.
module tb_nios_mult_pipe;
  localparam int DW  = 32;
  localparam int PS  = 2;
  localparam int PCW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] E_src1 = '0, E_src2 = '0;
  logic [1:0]    E_op = '0;
  logic          E_valid = 1'b0, M_en = 1'b0, flush = 1'b0;
  logic [DW-1:0] M_mul_result;
  logic          M_mul_valid, M_mul_busy;
`ifdef MULT_PIPE_PERF_CNT_EN
  logic [PCW-1:0] perf_mul_count;
`endif

  always #5 clk = ~clk;

  nios_mult_pipe #(.DATA_W(DW), .PIPE_STAGES(PS), .PERF_CNT_W(PCW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_op         (E_op),
    .E_valid      (E_valid),
    .M_en         (M_en),
    .flush        (flush),
    .M_mul_result (M_mul_result),
    .M_mul_valid  (M_mul_valid),
    .M_mul_busy   (M_mul_busy)
`ifdef MULT_PIPE_PERF_CNT_EN
    ,
    .perf_mul_count (perf_mul_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // In-flight op: its result and the register it occupies (1..PS, PS = visible at output).
  typedef struct {
    logic [DW-1:0] res;
    int            pos;
  } ent_t;
  ent_t           pipe_m[$];
  logic [PCW-1:0] cnt_m = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_mul(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [2*DW-1:0] ae, be, p;
    ae = (op == 2'd1 || op == 2'd2) ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    be = (op == 2'd1) ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    p  = ae * be;
    return (op == 2'd0) ? p[DW-1:0] : p[2*DW-1:DW];
  endfunction

  function automatic void model_edge(input logic ev, input logic en, input logic fl,
                                     input logic [1:0] op, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
    ent_t nq[$];
    if (en) foreach (pipe_m[i]) if (pipe_m[i].pos == PS) cnt_m++;
    if (fl) begin
      pipe_m.delete();
    end else if (en) begin
      foreach (pipe_m[i]) if (pipe_m[i].pos < PS) nq.push_back('{pipe_m[i].res, pipe_m[i].pos + 1});
      if (ev) nq.push_back('{ref_mul(op, a, b), 1});
      pipe_m = nq;
    end
  endfunction

  task automatic compare_all(input string tag);
    logic          ev, eb;
    logic [DW-1:0] er;
    ev = 1'b0; eb = 1'b0; er = '0;
    foreach (pipe_m[i]) begin
      if (pipe_m[i].pos == PS) begin ev = 1'b1; er = pipe_m[i].res; end
      else eb = 1'b1;
    end
    check_eq({tag, ".valid"}, 64'(M_mul_valid), 64'(ev));
    check_eq({tag, ".busy"}, 64'(M_mul_busy), 64'(eb));
    if (ev) check_eq({tag, ".res"}, 64'(M_mul_result), 64'(er));
`ifdef MULT_PIPE_PERF_CNT_EN
    check_eq({tag, ".perf"}, 64'(perf_mul_count), 64'(cnt_m));
`endif
  endtask

  task automatic step(input string tag, input logic ev, input logic en, input logic fl,
                      input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    E_valid = ev; M_en = en; flush = fl; E_op = op; E_src1 = a; E_src2 = b;
    @(posedge clk);
    model_edge(ev, en, fl, op, a, b);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    pipe_m.delete();
    cnt_m = '0;
    check_eq({tag, ".valid"}, 64'(M_mul_valid), 64'd0);
    check_eq({tag, ".busy"}, 64'(M_mul_busy), 64'd0);
    check_eq({tag, ".res"}, 64'(M_mul_result), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(DW-1){1'b0}}};
      default: return DW'($urandom());
    endcase
  endfunction

  logic [DW-1:0] exp4 [4];

  initial begin
    #12;
    do_reset("reset");

    // Low-word basic multiply and its latency
    step("mul_issue", 1'b1, 1'b1, 1'b0, 2'd0, 32'h0001_0003, 32'h0002_0005);
    idle("mul_out");
    check_eq("mul_const", 64'(M_mul_result), 64'h000B_000F);
    idle("mul_drain");

    // High-word variants of -1 x -1
    step("mulh", 1'b1, 1'b1, 1'b0, 2'd1, '1, '1);
    step("mulhu", 1'b1, 1'b1, 1'b0, 2'd3, '1, '1);
    check_eq("mulh_const", 64'(M_mul_result), 64'h0);
    step("mulhsu", 1'b1, 1'b1, 1'b0, 2'd2, '1, '1);
    check_eq("mulhu_const", 64'(M_mul_result), 64'hFFFF_FFFE);
    idle("hi_drain");
    check_eq("mulhsu_const", 64'(M_mul_result), 64'hFFFF_FFFF);
    idle("hi_drain2");

    // Back-to-back issue
    exp4 = '{32'd0, 32'd1, 32'd1, 32'd2};
    for (int i = 0; i < 4; i++) begin
      step("b2b", 1'b1, 1'b1, 1'b0, 2'd3, DW'(i + 1), 32'h8000_0000);
      if (i > 0) check_eq("b2b_const", 64'(M_mul_result), 64'(exp4[i-1]));
    end
    idle("b2b_last");
    check_eq("b2b_const", 64'(M_mul_result), 64'(exp4[3]));
    idle("b2b_drain");

    // Stall mid-flight, then stall with result presented
    step("stall_issue", 1'b1, 1'b1, 1'b0, 2'd0, 32'd7, 32'd9);
    for (int i = 0; i < 3; i++) step("stall_mid", 1'b0, 1'b0, 1'b0, 2'd0, '0, '0);
    idle("stall_out");
    check_eq("stall_const", 64'(M_mul_result), 64'd63);
    for (int i = 0; i < 2; i++) step("stall_hold", 1'b1, 1'b0, 1'b0, 2'd0, '1, '1);
    check_eq("stall_hold_const", 64'(M_mul_result), 64'd63);
    idle("stall_once");
    idle("stall_once2");

    // Flush beats a simultaneous new op
    step("flush_issue", 1'b1, 1'b1, 1'b0, 2'd0, 32'd5, 32'd6);
    step("flush", 1'b1, 1'b1, 1'b1, 2'd0, 32'd3, 32'd3);
    check_eq("flush_busy", 64'(M_mul_busy), 64'd0);
    idle("flush_after");
    idle("flush_after2");

    // Asynchronous reset mid-flight
    step("rst_issue", 1'b1, 1'b1, 1'b0, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    step("rst_issue2", 1'b1, 1'b1, 1'b0, 2'd3, 32'hFFFF_0000, 32'h0000_FFFF);
    do_reset("rst_mid");
    idle("rst_after");
    idle("rst_after2");

`ifdef MULT_PIPE_PERF_CNT_EN
    for (int i = 0; i < 17; i++) step("perf_ops", 1'b1, 1'b1, 1'b0, 2'd0, DW'(i), 32'd3);
    idle("perf_drain");
    idle("perf_drain2");
    check_eq("perf_wrap", 64'(perf_mul_count), 64'd1);
    step("perf_f1", 1'b1, 1'b1, 1'b0, 2'd0, 32'd1, 32'd1);
    step("perf_f2", 1'b1, 1'b1, 1'b0, 2'd0, 32'd2, 32'd2);
    step("perf_stall", 1'b0, 1'b0, 1'b0, 2'd0, '0, '0);
    step("perf_flush", 1'b0, 1'b0, 1'b1, 2'd0, '0, '0);
    check_eq("perf_flushed", 64'(perf_mul_count), 64'd1);
`endif

    // Random traffic with stalls and occasional flushes
    for (int i = 0; i < 800; i++) begin
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), rnd_operand(),
           rnd_operand());
    end
    for (int i = 0; i < PS + 1; i++) idle("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
